// File: rtl/ram_req_master.sv
// Initiator for the single-port image-RAM handshake: sequences address, one-cycle
// write enable and ready-strobe waits, with a per-access timeout and debug counters.
module ram_req_master #(
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              cmd_ready,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q,
  input  logic              mem_ready_we,
  input  logic              mem_ready_re,
  output logic [CNT_W-1:0]  txn_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam int TMR_W = $clog2(TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_WR_PULSE, S_WAIT_WR, S_WAIT_RD, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_we_q, mem_we_d;
  logic              we_q, we_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]  txn_count_q, txn_count_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;

  // NOTE: every _d starts as its _q so no path through the case leaves a signal
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_we_d    = mem_we_q;
    we_d        = we_q;
    timer_d     = timer_q;
    txn_count_d = txn_count_q;
    err_count_d = err_count_q;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          mem_addr_d  = cmd_addr;
          if (cmd_we) mem_data_d = cmd_wdata;
          we_d        = cmd_we;
          cmd_ready_d = 1'b0;
          state_d     = S_SETUP;
        end
      end
      // Address settles for one cycle before we so the RAM never sees both move together.
      S_SETUP: begin
        if (we_q) begin
          mem_we_d = 1'b1;
          state_d  = S_WR_PULSE;
        end else begin
          timer_d = '0;
          state_d = S_WAIT_RD;
        end
      end
      S_WR_PULSE: begin
        mem_we_d = 1'b0;
        timer_d  = '0;
        state_d  = S_WAIT_WR;
      end
      S_WAIT_WR: begin
        if (mem_ready_we) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          state_d     = S_DONE;
        end else if (timer_q == TMR_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = S_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_RD: begin
        if (mem_ready_re) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = mem_q;
          state_d     = S_DONE;
        end else if (timer_q == TMR_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = S_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: begin
        rsp_valid_d = 1'b0;
        txn_count_d = txn_count_q + 1'b1;
        if (rsp_err_q && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_we_q    <= 1'b0;
      we_q        <= 1'b0;
      timer_q     <= '0;
      txn_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_we_q    <= mem_we_d;
      we_q        <= we_d;
      timer_q     <= timer_d;
      txn_count_q <= txn_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign mem_we    = mem_we_q;
  assign txn_count = txn_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_ram_req_master.sv
// Scoreboard bench for ram_req_master: stimulus pushes expected responses, a
// negedge monitor pops and compares them; a byte-array RAM model answers strobes.
module tb_ram_req_master;
  localparam int ADDR_W  = 19;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_we = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              cmd_ready;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_we;
  logic [DATA_W-1:0] mem_q = '0;
  logic              mem_ready_we = 1'b0;
  logic              mem_ready_re = 1'b0;
  logic [CNT_W-1:0]  txn_count;
  logic [CNT_W-1:0]  err_count;

  ram_req_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q),
    .mem_ready_we(mem_ready_we), .mem_ready_re(mem_ready_re),
    .txn_count(txn_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          err;
    logic [7:0]  rdata;
    int          at;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  ref_mem[int];
  logic [7:0]  ram_mem[int];
  logic [7:0]  last_rd = 8'h00;
  int          exp_txn = 0;
  int          exp_err = 0;
  int          writes_issued = 0;
  int          we_seen = 0;
  logic [ADDR_W-1:0] exp_waddr = '0;
  logic [DATA_W-1:0] exp_wdata = '0;
  bit          prev_we = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ram_rd(input int a);
    return ram_mem.exists(a) ? ram_mem[a] : 8'h00;
  endfunction

  // RAM model: a byte lands wherever the pulse of we points.
  always @(posedge clk) begin
    if (mem_we) ram_mem[int'(mem_addr)] = mem_data;
  end

  // Monitor: compares each completion and each write-enable pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_cycle", cyc, e.at);
          check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
        end
      end
      if (mem_we) begin
        we_seen++;
        check("we_addr", {13'd0, mem_addr}, {13'd0, exp_waddr});
        check("we_data", {24'd0, mem_data}, {24'd0, exp_wdata});
        check("we_width", {31'd0, prev_we}, 32'd0);
      end
      prev_we = mem_we;
    end else begin
      prev_we = 1'b0;
    end
  end

  // Call at a negedge; returns at a negedge with cmd_ready high or a failure logged.
  task automatic wait_ready();
    int i;
    for (i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
    if (!cmd_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // One command end to end. d = wait cycles before the strobe (0 = first wait cycle).
  task automatic do_cmd(input bit we, input logic [ADDR_W-1:0] addr, input logic [7:0] wdata,
                        input int d, input bit respond, input bit stray);
    int   acc, lat, at;
    exp_t e;
    wait_ready();
    exp_waddr = addr;
    exp_wdata = wdata;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    @(posedge clk);
    #1;
    acc = cyc;
    lat = we ? 3 : 2;
    at  = respond ? acc + lat + d : acc + lat + TIMEOUT - 1;

    if (we) begin
      ref_mem[int'(addr)] = wdata;
      writes_issued++;
    end else if (respond) begin
      last_rd = ref_rd(int'(addr));
    end
    e.err   = !respond;
    e.rdata = last_rd;
    e.at    = at;
    exp_q.push_back(e);
    exp_txn++;
    if (!respond) exp_err++;

    while (cyc < at) begin
      @(negedge clk);
      // Busy-time command inputs are noise that must be ignored.
      cmd_valid = (cyc < at);
      cmd_we    = 1'($urandom);
      cmd_addr  = ADDR_W'($urandom);
      cmd_wdata = 8'($urandom);
      mem_q     = 8'($urandom);
      if (stray && cyc == acc + lat) begin
        if (we) mem_ready_re = 1'b1;
        else    mem_ready_we = 1'b1;
      end else begin
        mem_ready_re = 1'b0;
        mem_ready_we = 1'b0;
      end
      if (respond && cyc == at - 1) begin
        if (we) mem_ready_we = 1'b1;
        else begin
          mem_ready_re = 1'b1;
          mem_q        = ram_rd(int'(addr));
        end
      end
    end
    cmd_valid    = 1'b0;
    mem_ready_we = 1'b0;
    mem_ready_re = 1'b0;
    @(negedge clk);
    check("ready_back", {31'd0, cmd_ready}, 32'd1);
    check("txn_count", {16'd0, txn_count}, 32'(exp_txn & 16'hFFFF));
    check("err_count", {16'd0, err_count}, 32'(exp_err));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    check({tag, "_rsp_rdata"}, {24'd0, rsp_rdata}, 32'd0);
    check({tag, "_mem_addr"}, {13'd0, mem_addr}, 32'd0);
    check({tag, "_mem_data"}, {24'd0, mem_data}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_txn_count"}, {16'd0, txn_count}, 32'd0);
    check({tag, "_err_count"}, {16'd0, err_count}, 32'd0);
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    int                d;

    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst = 1'b0;
    @(negedge clk);
    check("por_ready_rise", {31'd0, cmd_ready}, 32'd1);

    // Write then read back with long waits; rdata must survive a later write.
    do_cmd(1'b1, 19'h00003, 8'hA0, 8, 1'b1, 1'b0);
    do_cmd(1'b0, 19'h00003, 8'h00, 8, 1'b1, 1'b0);
    do_cmd(1'b1, 19'h00010, 8'h55, 1, 1'b1, 1'b0);
    check("rdata_hold", {24'd0, rsp_rdata}, 32'h0000_00A0);

    // Minimum-latency back-to-back reads.
    do_cmd(1'b1, 19'h00008, 8'h3C, 0, 1'b1, 1'b0);
    do_cmd(1'b1, 19'h00009, 8'hC3, 0, 1'b1, 1'b0);
    do_cmd(1'b0, 19'h00008, 8'h00, 0, 1'b1, 1'b0);
    do_cmd(1'b0, 19'h00009, 8'h00, 0, 1'b1, 1'b0);

    // Timeouts on both directions, then normal traffic.
    do_cmd(1'b1, 19'h00020, 8'h77, 0, 1'b0, 1'b0);
    do_cmd(1'b0, 19'h00021, 8'h00, 0, 1'b0, 1'b0);
    do_cmd(1'b0, 19'h00020, 8'h00, 2, 1'b1, 1'b0);

    // Stray strobes while idle, then wrong-direction strobes during waits.
    mem_ready_we = 1'b1;
    mem_ready_re = 1'b1;
    @(negedge clk);
    mem_ready_we = 1'b0;
    mem_ready_re = 1'b0;
    repeat (3) @(negedge clk);
    do_cmd(1'b1, 19'h7FF05, 8'h9E, 5, 1'b1, 1'b1);
    do_cmd(1'b0, 19'h7FF05, 8'h00, 4, 1'b1, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 1) != 0 ? 19'h7FF00 : 19'h00000) | ADDR_W'($urandom_range(0, 15));
      d = $urandom_range(0, 10);
      do_cmd(1'($urandom), a, 8'($urandom), d, $urandom_range(0, 7) != 0,
             (d >= 3) && ($urandom_range(0, 1) != 0));
    end

    // Reset while a read is waiting for its strobe.
    wait_ready();
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 19'h00008;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values("mid");
    @(negedge clk);
    rst = 1'b0;
    exp_txn = 0;
    exp_err = 0;
    last_rd = 8'h00;
    @(negedge clk);
    check("mid_ready_rise", {31'd0, cmd_ready}, 32'd1);
    repeat (80) @(negedge clk);
    do_cmd(1'b0, 19'h00009, 8'h00, 1, 1'b1, 1'b0);

    check("queue_drained", exp_q.size(), 32'd0);
    check("we_pulses", we_seen, writes_issued);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
